imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_word_assembler.sv | 31 +++
 rtl/imem_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared state encoding and frame constants for the instruction-memory boot loader.
// The CHECK state is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  typedef logic [2:0] loaderState_t;

  localparam loaderState_t HDR_HI = 3'd0;
  localparam loaderState_t HDR_LO = 3'd1;
  localparam loaderState_t DATA   = 3'd2;
  localparam loaderState_t CHECK  = 3'd3;
  localparam loaderState_t DONE   = 3'd4;
  localparam loaderState_t ERR    = 3'd5;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian 8-to-32 assembler: wordValid strobes combinationally with the 4th accepted byte,
// and wordData presents the completed word in that same cycle.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byteValid,
  input  logic [7:0]  byteData,
  output logic        wordValid,
  output logic [31:0] wordData
);

  logic [23:0] shiftReg;
  logic [1:0]  byteCount;

  assign wordValid = byteValid && (byteCount == 2'(BYTES_PER_WORD - 1));
  assign wordData  = {shiftReg, byteData};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shiftReg  <= '0;
      byteCount <= '0;
    end else if (byteValid) begin
      shiftReg  <= {shiftReg[15:0], byteData};
      byteCount <= byteCount + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: framed byte stream in, one word write per 4 bytes, CPU held until done.
// Optional trailing XOR checksum when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  loaderState_t state;
  logic [15:0]  wordCount;
  logic [15:0]  wordIdx;
  logic         donePend;
  logic         inAccept;
  logic         rearm;
  logic [15:0]  hdrCount;
  logic         hdrTooBig;
  logic         wordLast;
  logic         wordValid;
  logic [31:0]  wordData;

  assign in_ready  = (state != DONE) && (state != ERR);
  assign inAccept  = in_valid && in_ready;
  assign rearm     = start && ((state == DONE) || (state == ERR));
  assign hdrCount  = {wordCount[15:8], in_data};
  assign hdrTooBig = {17'd0, hdrCount} > MAX_WORDS;
  assign wordLast  = (17'(wordIdx) + 17'd1) == {1'b0, wordCount};

  imem_loader_word_assembler uWordAssembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (rearm),
    .byteValid (inAccept && (state == DATA)),
    .byteData  (in_data),
    .wordValid (wordValid),
    .wordData  (wordData)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] checksum;

  always_ff @(posedge clk) begin
    if (reset || rearm) begin
      checksum <= '0;
    end else if (inAccept && (state != CHECK)) begin
      checksum <= checksum ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HDR_HI;
      wordCount <= '0;
      wordIdx   <= '0;
      donePend  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= ADDR_W'(BASE_ADDR);
      mem_data  <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (wordValid) begin
        mem_we   <= 1'b1;
        mem_addr <= ADDR_W'(BASE_ADDR + int'(wordIdx));
        mem_data <= wordData;
        wordIdx  <= wordIdx + 16'd1;
      end

      // Completion is delayed a cycle so the final write lands before the CPU is released.
      if (donePend) begin
        donePend <= 1'b0;
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end

      case (state)
        HDR_HI: begin
          if (inAccept) begin
            wordCount[15:8] <= in_data;
            state           <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (inAccept) begin
            wordCount[7:0] <= in_data;
            if (hdrCount == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CHECK;
`else
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else if (hdrTooBig) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (wordValid && wordLast) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= CHECK;
`else
            state    <= DONE;
            donePend <= 1'b1;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (inAccept) begin
            if (in_data == checksum) begin
              state <= DONE;
              // A write still pulsing means the trailer arrived right behind it; wait one more cycle.
              if (mem_we) begin
                donePend <= 1'b1;
              end else begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        DONE, ERR: begin
          if (start) begin
            state    <= HDR_HI;
            wordIdx  <= '0;
            donePend <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end
        default: state <= HDR_HI;
      endcase
    end
  end

endmodule
